// File: rtl/gaussian_frame_ctrl.sv
// gfc_fifo: small generic FIFO with occupancy count; DEPTH must be a power of two.
// Latency: 1 cycle write-to-read; head is visible combinationally on rd_dat.
// Backpressure: writes are dropped when full unless a read happens in the same cycle.
module gfc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign rd_vld = (count != '0);
  assign rd_ok  = rd_vld && rd_rdy;
  assign wr_ok  = wr_vld && ((count != CW'(DEPTH)) || rd_ok);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

// gaussian_frame_ctrl: frame sequencer for a 5x5 Gaussian core; status ports under GAUSS_FRAME_CTRL_STATUS_EN.
// Latency: CORE_LATENCY enabled core cycles from window-complete pixel to capture, +1 cycle to m_valid.
// Backpressure: input and core stall whenever FIFO occupancy plus an in-flight capture reaches 2.
module gaussian_frame_ctrl #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int DIM_WIDTH    = 12,
  parameter int CORE_LATENCY = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   cfg_width,
  input  logic [DIM_WIDTH-1:0]   cfg_height,
  output logic                   busy,
  output logic                   frame_done,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   lb_wr_en,
  output logic [DIM_WIDTH-1:0]   lb_col,
  output logic [PIXEL_WIDTH-1:0] lb_pixel,
  output logic                   core_enable,
  output logic                   core_valid_in,
  input  logic [PIXEL_WIDTH-1:0] core_pixel_out,
  input  logic                   core_valid_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   m_user
`ifdef GAUSS_FRAME_CTRL_STATUS_EN
  ,
  output logic [15:0]            frame_count,
  output logic                   err_line
`endif
);
  localparam int FW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [DIM_WIDTH-1:0]   w_q, h_q, in_x, in_y, out_x;
  logic [FW-1:0]          flush_cnt;
  logic                   core_adv_q, first_q;
  logic [1:0]             fifo_count;
  logic [PIXEL_WIDTH-1:0] fifo_head;
  logic                   fifo_vld;
  logic                   start_go, space_ok, accept, flush_go, capture, pop;
  logic                   last_px, drain_done, x_at_end;

  assign start_go   = (state == IDLE) && start &&
                      (cfg_width >= DIM_WIDTH'(5)) && (cfg_height >= DIM_WIDTH'(5));
  // A capture pending from last cycle's core step still needs a FIFO slot.
  assign space_ok   = (fifo_count + {1'b0, core_adv_q}) < 2'd2;
  assign accept     = s_valid && s_ready;
  assign x_at_end   = (in_x == w_q - DIM_WIDTH'(1));
  assign last_px    = x_at_end && (in_y == h_q - DIM_WIDTH'(1));
  assign drain_done = (fifo_count == 2'd0) && !core_adv_q;
  assign capture    = core_adv_q && core_valid_out;
  assign pop        = m_valid && m_ready;

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    core_enable = 1'b0;
    flush_go    = 1'b0;
    case (state)
      IDLE:  if (start_go) state_nxt = RUN;
      RUN: begin
        s_ready     = space_ok;
        core_enable = s_valid && space_ok;
        if (s_valid && space_ok && last_px) state_nxt = FLUSH;
      end
      FLUSH: begin
        flush_go    = space_ok;
        core_enable = space_ok;
        if (space_ok && (flush_cnt == FW'(CORE_LATENCY - 1))) state_nxt = DRAIN;
      end
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign lb_wr_en      = accept;
  assign lb_col        = accept ? in_x : '0;
  assign lb_pixel      = accept ? s_data : '0;
  assign core_valid_in = accept && (in_x >= DIM_WIDTH'(4)) && (in_y >= DIM_WIDTH'(4));
  assign m_valid       = fifo_vld;
  assign m_data        = fifo_vld ? fifo_head : '0;
  assign m_last        = fifo_vld && (out_x == w_q - DIM_WIDTH'(5));
  assign m_user        = fifo_vld && first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      in_x       <= '0;
      in_y       <= '0;
      out_x      <= '0;
      flush_cnt  <= '0;
      core_adv_q <= 1'b0;
      first_q    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_adv_q <= core_enable;
      frame_done <= (state == DRAIN) && drain_done;
      if (start_go) begin
        w_q       <= cfg_width;
        h_q       <= cfg_height;
        in_x      <= '0;
        in_y      <= '0;
        out_x     <= '0;
        flush_cnt <= '0;
        first_q   <= 1'b1;
      end
      if (accept) begin
        if (x_at_end) begin
          in_x <= '0;
          in_y <= in_y + DIM_WIDTH'(1);
        end else begin
          in_x <= in_x + DIM_WIDTH'(1);
        end
      end
      if (flush_go) flush_cnt <= flush_cnt + FW'(1);
      if (pop) begin
        first_q <= 1'b0;
        out_x   <= (out_x == w_q - DIM_WIDTH'(5)) ? '0 : out_x + DIM_WIDTH'(1);
      end
    end
  end

  gfc_fifo #(.WIDTH(PIXEL_WIDTH), .DEPTH(2)) u_out_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (capture),
    .wr_dat (core_pixel_out),
    .rd_rdy (m_ready),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_head),
    .count  (fifo_count)
  );

`ifdef GAUSS_FRAME_CTRL_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      err_line    <= 1'b0;
    end else begin
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (start_go) err_line <= 1'b0;
      else if (accept && (s_last != x_at_end)) err_line <= 1'b1;
    end
  end
`else
  logic s_last_unused;
  assign s_last_unused = s_last;
`endif
endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Bench for gaussian_frame_ctrl: mock core pipeline plus a raster-order reference of expected outputs.
module tb_gaussian_frame_ctrl;
  localparam int PW  = 8;
  localparam int DW  = 12;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst, start, s_valid, s_last, m_ready;
  logic [DW-1:0] cfg_width, cfg_height, lb_col;
  logic [PW-1:0] s_data, lb_pixel, core_pixel_out, m_data;
  logic busy, frame_done, s_ready, lb_wr_en, core_enable, core_valid_in, core_valid_out;
  logic m_valid, m_last, m_user;
`ifdef GAUSS_FRAME_CTRL_STATUS_EN
  logic [15:0] frame_count;
  logic        err_line;
`endif

  int vectors, miscompares;
  logic [PW-1:0] pix [256];
  logic [9:0] exp_q[$], got_q[$], ramp_q[$];
  int got_n, seq_err, lb_err, en_err, flow_err, flush_en, done_cnt, timeout, stall_cyc;
  int last_pop_cyc, done_cyc;

  always #5 clk = ~clk;

  gaussian_frame_ctrl #(.PIXEL_WIDTH(PW), .DIM_WIDTH(DW), .CORE_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .frame_done(frame_done), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .lb_wr_en(lb_wr_en), .lb_col(lb_col),
    .lb_pixel(lb_pixel), .core_enable(core_enable), .core_valid_in(core_valid_in),
    .core_pixel_out(core_pixel_out), .core_valid_out(core_valid_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_user(m_user)
`ifdef GAUSS_FRAME_CTRL_STATUS_EN
    , .frame_count(frame_count), .err_line(err_line)
`endif
  );

  // Mock core: LAT-stage pipeline stepped only by core_enable, forwarding the window's newest pixel.
  logic [LAT-1:0] core_v;
  logic [PW-1:0]  core_p [LAT];
  always @(posedge clk) begin
    if (rst) core_v <= '0;
    else if (core_enable) begin
      core_v    <= {core_v[LAT-2:0], core_valid_in};
      core_p[0] <= lb_pixel;
      for (int i = 1; i < LAT; i++) core_p[i] <= core_p[i-1];
    end
  end
  assign core_valid_out = core_v[LAT-1];
  assign core_pixel_out = core_p[LAT-1];

  // Runs one frame from pix[]; rmode 0=ready always, 1=random, 2=low for cycles 38..57.
  task automatic drive_frame(input int w, input int h, input int vmode, input int rmode,
                             input int abort_cyc, input bit mid_start, input bit bad_last);
    int idx, cyc, occ, n, x, y;
    bit en_prev, prev_stall, acc, pop, cap;
    logic [PW-1:0] prev_dat;
    n = w * h;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < n; i++)
      if ((i % w) >= 4 && (i / w) >= 4)
        exp_q.push_back({exp_q.size() == 0, (i % w) == w - 1, pix[i]});
    got_n = 0; seq_err = 0; lb_err = 0; en_err = 0; flow_err = 0; flush_en = 0;
    done_cnt = 0; timeout = 0; stall_cyc = 0; last_pop_cyc = -100; done_cyc = -1;
    idx = 0; cyc = 0; occ = 0; en_prev = 0; prev_stall = 0; prev_dat = '0;
    @(negedge clk);
    start = 1'b1; cfg_width = DW'(w); cfg_height = DW'(h);
    @(negedge clk);
    forever begin
      x = idx % w;
      y = idx / w;
      s_valid = (idx < n) && (vmode == 0 || $urandom_range(0, 3) != 0);
      s_data  = (idx < n) ? pix[idx] : PW'($urandom);
      s_last  = ((x == w - 1) != (bad_last && idx == 3));
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 2) != 0);
        default: m_ready = !(cyc >= 38 && cyc < 58);
      endcase
      start = mid_start && (cyc == 15);
      if (start) begin cfg_width = DW'(5); cfg_height = DW'(5); end
      #1;
      acc = (s_valid && s_ready === 1'b1);
      if (acc) begin
        if (lb_wr_en !== 1'b1 || lb_col !== DW'(x) || lb_pixel !== s_data ||
            core_valid_in !== (x >= 4 && y >= 4)) lb_err++;
      end else if (lb_wr_en !== 1'b0 || core_valid_in !== 1'b0) lb_err++;
      if (idx < n) begin
        if (core_enable !== acc) en_err++;
      end else if (core_enable === 1'b1) flush_en++;
      cap = en_prev && (core_valid_out === 1'b1);
      pop = (m_valid === 1'b1) && m_ready;
      if (m_valid !== (occ > 0)) flow_err++;
      if (occ == 2 && (s_ready !== 1'b0 || core_enable !== 1'b0)) flow_err++;
      if (idx < n && occ + int'(en_prev) < 2 && s_ready !== 1'b1) flow_err++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_dat)) flow_err++;
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy !== 1'b0 || occ != 0) flow_err++;
        if (got_n != exp_q.size()) seq_err++;
      end else if (done_cnt == 0 && busy !== 1'b1) flow_err++;
      if (pop) begin
        got_q.push_back({m_user, m_last, m_data});
        if (got_n >= exp_q.size() || {m_user, m_last, m_data} !== exp_q[got_n]) seq_err++;
        got_n++;
        last_pop_cyc = cyc;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_dat   = m_data;
      if (prev_stall) stall_cyc++;
      occ = occ + int'(cap) - int'(pop);
      if (occ > 2 || occ < 0) flow_err++;
      en_prev = (core_enable === 1'b1);
      if (acc) idx++;
      if (abort_cyc > 0 && cyc == abort_cyc) break;
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      if (cyc >= 3000) begin timeout = 1; break; end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({busy, s_ready, m_valid, core_enable, frame_done, lb_wr_en, core_valid_in, m_last, m_user} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {busy, s_ready, m_valid, core_enable, frame_done, lb_wr_en, core_valid_in, m_last, m_user});
    end
    vectors++;
    if ({m_data, lb_col, lb_pixel} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: m_data=%0h lb_col=%0h lb_pixel=%0h want 0", m_data, lb_col, lb_pixel);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_window();
    logic [9:0] want;
    want = {2'b11, 8'd100};
    for (int i = 0; i < 25; i++) pix[i] = 8'd100;
    drive_frame(5, 5, 0, 0, 0, 0, 0);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      miscompares++;
      $display("FAIL single_out: got %0d outputs first=%h want 1 output %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 10'h0, want);
    end
    vectors++;
    if (done_cnt != 1 || timeout != 0) begin
      miscompares++;
      $display("FAIL single_done: frame_done pulses=%0d timeout=%0d want 1,0", done_cnt, timeout);
    end
    vectors++;
    if (done_cyc - last_pop_cyc != 2) begin
      miscompares++;
      $display("FAIL single_done_timing: frame_done %0d cycles after last pop, want 2", done_cyc - last_pop_cyc);
    end
    vectors++;
    if (flush_en != LAT || lb_err + en_err + flow_err != 0) begin
      miscompares++;
      $display("FAIL single_proto: flush=%0d lb=%0d en=%0d flow=%0d want %0d,0,0,0",
               flush_en, lb_err, en_err, flow_err, LAT);
    end
  endtask

  task automatic test_ramp();
    int lasts, users;
    for (int i = 0; i < 48; i++) pix[i] = PW'(i);
    drive_frame(8, 6, 0, 0, 0, 0, 0);
    ramp_q = got_q;
    lasts = 0; users = 0;
    foreach (got_q[i]) begin
      lasts += int'(got_q[i][8]);
      users += int'(got_q[i][9]);
    end
    vectors++;
    if (got_n != 8 || seq_err != 0) begin
      miscompares++;
      $display("FAIL ramp_seq: got %0d outputs, %0d wrong; want 8 outputs, 0 wrong", got_n, seq_err);
    end
    vectors++;
    if (got_q.size() != 8 || lasts != 2 || got_q[3][8] !== 1'b1 || got_q[7][8] !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_last: m_last count=%0d want 2 on outputs 4 and 8", lasts);
    end
    vectors++;
    if (got_q.size() == 0 || users != 1 || got_q[0][9] !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_user: m_user count=%0d want 1 on first output", users);
    end
    vectors++;
    if (done_cnt != 1 || timeout != 0 || flush_en != LAT || lb_err + en_err + flow_err != 0) begin
      miscompares++;
      $display("FAIL ramp_proto: done=%0d to=%0d flush=%0d lb=%0d en=%0d flow=%0d",
               done_cnt, timeout, flush_en, lb_err, en_err, flow_err);
    end
  endtask

  task automatic test_backpressure();
    int diffs;
    drive_frame(8, 6, 0, 2, 0, 0, 0);
    diffs = (got_q.size() == ramp_q.size()) ? 0 : 1;
    foreach (got_q[i]) if (i < ramp_q.size() && got_q[i] !== ramp_q[i]) diffs++;
    vectors++;
    if (diffs != 0 || seq_err != 0 || got_n != 8) begin
      miscompares++;
      $display("FAIL bp_seq: got %0d outputs, %0d differ from unstalled run, %0d wrong", got_n, diffs, seq_err);
    end
    vectors++;
    if (stall_cyc == 0) begin
      miscompares++;
      $display("FAIL bp_stall: stalled cycles=%0d want >0", stall_cyc);
    end
    vectors++;
    if (flow_err + en_err + lb_err != 0 || done_cnt != 1 || timeout != 0) begin
      miscompares++;
      $display("FAIL bp_proto: flow=%0d en=%0d lb=%0d done=%0d to=%0d", flow_err, en_err, lb_err, done_cnt, timeout);
    end
  endtask

  task automatic test_random();
    int w, h;
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(5, 12);
      h = $urandom_range(5, 12);
      for (int i = 0; i < w * h; i++) pix[i] = PW'($urandom);
      drive_frame(w, h, 1, 1, 0, 0, 0);
      vectors++;
      if (got_n != exp_q.size() || seq_err != 0) begin
        miscompares++;
        $display("FAIL rand_seq %0dx%0d: got %0d outputs, %0d wrong; want %0d", w, h, got_n, seq_err, exp_q.size());
      end
      vectors++;
      if (done_cnt != 1 || timeout != 0) begin
        miscompares++;
        $display("FAIL rand_done %0dx%0d: pulses=%0d timeout=%0d want 1,0", w, h, done_cnt, timeout);
      end
      vectors++;
      if (flush_en != LAT || lb_err + en_err + flow_err != 0) begin
        miscompares++;
        $display("FAIL rand_proto %0dx%0d: flush=%0d lb=%0d en=%0d flow=%0d", w, h, flush_en, lb_err, en_err, flow_err);
      end
    end
  endtask

  task automatic test_bad_start();
    @(negedge clk);
    start = 1'b1; cfg_width = DW'(4); cfg_height = DW'(6);
    @(negedge clk);
    start = 1'b1; cfg_width = DW'(6); cfg_height = DW'(4);
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL small_start: busy=%b s_ready=%b want 0,0", busy, s_ready);
    end
    for (int i = 0; i < 48; i++) pix[i] = PW'(i);
    drive_frame(8, 6, 0, 0, 0, 1, 0);
    vectors++;
    if (got_n != 8 || seq_err != 0 || done_cnt != 1 || timeout != 0) begin
      miscompares++;
      $display("FAIL start_in_run: outputs=%0d wrong=%0d done=%0d to=%0d want 8,0,1,0", got_n, seq_err, done_cnt, timeout);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] want;
    want = {2'b11, 8'd100};
    for (int i = 0; i < 48; i++) pix[i] = PW'(i);
    drive_frame(8, 6, 0, 2, 46, 0, 0);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, m_valid, core_enable, s_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL mid_reset: busy,m_valid,core_enable,s_ready=%b want 0000", {busy, m_valid, core_enable, s_ready});
    end
    for (int i = 0; i < 25; i++) pix[i] = 8'd100;
    drive_frame(5, 5, 0, 0, 0, 0, 0);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== want || done_cnt != 1 || flow_err != 0) begin
      miscompares++;
      $display("FAIL post_reset_frame: outputs=%0d done=%0d flow=%0d want 1 output %h", got_q.size(), done_cnt, flow_err, want);
    end
  endtask

`ifdef GAUSS_FRAME_CTRL_STATUS_EN
  task automatic test_status();
    for (int i = 0; i < 48; i++) pix[i] = PW'(i);
    drive_frame(8, 6, 0, 0, 0, 0, 1);
    vectors++;
    if (err_line !== 1'b1) begin
      miscompares++;
      $display("FAIL err_line_set: got %b want 1", err_line);
    end
    vectors++;
    if (frame_count !== 16'd2) begin
      miscompares++;
      $display("FAIL frame_count: got %0d want 2", frame_count);
    end
    drive_frame(8, 6, 0, 0, 0, 0, 0);
    vectors++;
    if (err_line !== 1'b0 || frame_count !== 16'd3) begin
      miscompares++;
      $display("FAIL status_clear: err_line=%b frame_count=%0d want 0,3", err_line, frame_count);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    test_single_window();
    test_ramp();
    test_backpressure();
    test_random();
    test_bad_start();
    test_reset_mid();
`ifdef GAUSS_FRAME_CTRL_STATUS_EN
    test_status();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gaussian_frame_ctrl.md
GAUSSIAN_FRAME_CTRL -- requirements
Module: gaussian_frame_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PIXEL_WIDTH, 8, pixel bits.
  DIM_WIDTH, 12, frame width/height counter bits.
  CORE_LATENCY, 6, enabled cycles from core valid_in to core valid_out.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock.
  rst  in  1  synchronous reset, active-high.
  start  in  1  frame start pulse.
  cfg_width  in  DIM_WIDTH  frame width W.
  cfg_height  in  DIM_WIDTH  frame height H.
  busy  out  1  high outside IDLE.
  frame_done  out  1  one-cycle pulse at frame end.
  s_valid  in  1  input pixel valid.
  s_ready  out  1  input pixel accepted when high with s_valid.
  s_data  in  PIXEL_WIDTH  input pixel.
  s_last  in  1  last pixel of input line.
  lb_wr_en  out  1  line-buffer write strobe.
  lb_col  out  DIM_WIDTH  line-buffer column address.
  lb_pixel  out  PIXEL_WIDTH  line-buffer write data.
  core_enable  out  1  Gaussian core pipeline advance.
  core_valid_in  out  1  window-complete flag to core.
  core_pixel_out  in  PIXEL_WIDTH  core result.
  core_valid_out  in  1  core result valid.
  m_valid  out  1  output pixel valid.
  m_ready  in  1  downstream ready.
  m_data  out  PIXEL_WIDTH  filtered pixel.
  m_last  out  1  last pixel of output line.
  m_user  out  1  first pixel of output frame.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, RUN, FLUSH, DRAIN.
REQ-005 IDLE->RUN on start with cfg_width>=5 and cfg_height>=5; W and H latched at that edge; start otherwise ignored, including in any non-IDLE state.
REQ-006 accept = s_valid && s_ready; s_ready = (state==RUN) && space_ok, where space_ok = (fifo_count + core_adv_q) < 2 and core_adv_q is core_enable registered.
REQ-007 On accept: lb_wr_en=1, lb_col=in_x, lb_pixel=s_data, combinationally in the same cycle; in_x increments and wraps to 0 at W-1, then in_y increments.
REQ-008 core_enable SHALL be high only on accept cycles in RUN or on granted flush cycles in FLUSH; never during bubbles (preserves core column alignment).
REQ-009 core_valid_in = accept && in_x>=4 && in_y>=4; 0 in FLUSH.
REQ-010 Accepting pixel (W-1,H-1) SHALL move RUN->FLUSH.
REQ-011 FLUSH issues exactly CORE_LATENCY core_enable cycles, each gated by space_ok, then ->DRAIN.
REQ-012 Core result capture: when core_adv_q && core_valid_out, core_pixel_out is pushed into a 2-entry output FIFO; m_valid/m_data reflect FIFO head; pop on m_valid && m_ready; simultaneous push/pop keeps count.
REQ-013 Output frame is (W-4)x(H-4) pixels; out_x counts output handshakes; m_last=1 when out_x==W-5; m_user=1 on the first output of the frame only.
REQ-014 DRAIN->IDLE when FIFO empty and no capture pending; frame_done pulses on that transition edge.
REQ-015 Zero output pixels lost or duplicated under any m_ready pattern; m_data stable while m_valid && !m_ready.
REQ-016 busy = (state!=IDLE).

Reset
REQ-017 rst (sync, any state, including mid-frame) SHALL force IDLE; clear counters and FIFO; all outputs 0 except s_ready=0, m_valid=0, core_enable=0.
REQ-018 After reset the core pipeline is treated as empty; a new start is required.

Configuration
REQ-019 Macro GAUSS_FRAME_CTRL_STATUS_EN. Defined: adds outputs frame_count (16 bits, increments on frame_done, wraps at 0xFFFF->0) and err_line (sticky; set when accepted s_last != (in_x==W-1); cleared by rst or start). Undefined: neither port exists; s_last ignored.

Verification
REQ-020 W=5,H=5, all pixels 100, m_ready=1 -> exactly one output, m_data=100, m_user=1, m_last=1; frame_done one cycle after FIFO empties.
REQ-021 W=8,H=6 ramp, m_ready=1 -> 8 outputs, m_last on 4th and 8th, m_user on 1st only, 4 accepts-to-output alignment matches golden model.
REQ-022 Same frame, m_ready low 20 cycles mid-frame -> s_ready and core_enable drop within 1 cycle, fifo_count<=2, output sequence identical to REQ-021.
REQ-023 start with cfg_width=4 -> stays IDLE, busy=0; start while RUN -> ignored.
REQ-024 rst asserted mid-RUN -> next cycle IDLE, m_valid=0, core_enable=0; fresh 5x5 frame then passes REQ-020.
REQ-025 With GAUSS_FRAME_CTRL_STATUS_EN: s_last at in_x=3 of W=8 -> err_line=1 held; two frames -> frame_count=2.
